// File: rtl/br_tag_alloc_if.sv
// Interface bundling the dispatch, resolve and status signals of the
// branch-tag scheduler.
//   master : dispatch / branch-unit side (drives i_* requests)
//   slave  : br_tag_alloc itself (drives o_* results)
// Parameters:
//   WIDTH_BRM : width of a branch tag
//   NTAG      : number of tag slots (1 << WIDTH_BRM)
interface br_tag_alloc_if #(
    parameter int WIDTH_BRM = 4,
    parameter int NTAG      = 1 << WIDTH_BRM
);
    logic                 i_alloc_req;
    logic                 o_alloc_gnt;
    logic [WIDTH_BRM-1:0] o_alloc_tag;
    logic                 i_res_valid;
    logic [WIDTH_BRM-1:0] i_res_tag;
    logic                 i_res_kill;
    logic [NTAG-1:0]      o_live_mask;
    logic                 o_flush;
    logic [NTAG-1:0]      o_flush_mask;
    logic                 o_commit_valid;
    logic [WIDTH_BRM-1:0] o_commit_tag;
    logic                 o_full;
    logic                 o_empty;
    logic [WIDTH_BRM:0]   o_count;

    modport master (
        output i_alloc_req, i_res_valid, i_res_tag, i_res_kill,
        input  o_alloc_gnt, o_alloc_tag, o_live_mask, o_flush, o_flush_mask,
               o_commit_valid, o_commit_tag, o_full, o_empty, o_count
    );

    modport slave (
        input  i_alloc_req, i_res_valid, i_res_tag, i_res_kill,
        output o_alloc_gnt, o_alloc_tag, o_live_mask, o_flush, o_flush_mask,
               o_commit_valid, o_commit_tag, o_full, o_empty, o_count
    );
endinterface

// File: rtl/br_tag_alloc.sv
// Branch-tag scheduler for the branch execution unit.
// Hands out branch tags in program order, tracks them until resolved,
// retires them oldest-first, and on a mispredict kill frees every younger
// tag and reports it as a one-cycle flush mask.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : alloc req/gnt/tag, resolve valid/tag/kill, live mask,
//                  flush pulse + mask, commit pulse + tag, full/empty/count
// Optional feature (macro BR_TAG_ALLOC_PERF_EN):
//   o_kill_cnt  : saturating count of accepted kills
//   o_stall_cnt : saturating count of cycles with alloc request but no grant
module br_tag_alloc #(
    parameter int WIDTH_BRM = 4,
    parameter int NTAG      = 1 << WIDTH_BRM
) (
    input logic          i_clk,
    input logic          i_rst,
    br_tag_alloc_if.slave bus
`ifdef BR_TAG_ALLOC_PERF_EN
    ,
    output logic [31:0]  o_kill_cnt,
    output logic [31:0]  o_stall_cnt
`endif
);
    localparam int PW = WIDTH_BRM + 1;

    logic [PW-1:0]        head_reg, tail_reg, head_next, tail_next, count;
    logic [NTAG-1:0]      live_reg, live_next, resolved_reg, resolved_next;
    logic [NTAG-1:0]      kill_mask;
    logic                 flush_reg, commit_valid_reg;
    logic [NTAG-1:0]      flush_mask_reg;
    logic [WIDTH_BRM-1:0] commit_tag_reg;
    logic [WIDTH_BRM-1:0] head_idx, tail_idx, kill_off;
    logic                 full, empty, res_live, kill_acc, res_acc, gnt, commit_ok;

    assign head_idx  = head_reg[WIDTH_BRM-1:0];
    assign tail_idx  = tail_reg[WIDTH_BRM-1:0];
    assign count     = tail_reg - head_reg;
    assign full      = (count == PW'(NTAG));
    assign empty     = (count == '0);

    // Requests against a tag that is not in flight are dropped entirely.
    assign res_live  = bus.i_res_valid & live_reg[bus.i_res_tag];
    assign kill_acc  = res_live & bus.i_res_kill;
    assign res_acc   = res_live & ~bus.i_res_kill;
    assign gnt       = bus.i_alloc_req & ~full & ~kill_acc;

    // Age is the offset from head, so comparisons stay correct across wrap.
    assign kill_off  = bus.i_res_tag - head_idx;

    generate
        for (genvar gi = 0; gi < NTAG; gi++) begin : g_slot
            logic [WIDTH_BRM-1:0] slot_off;
            assign slot_off      = WIDTH_BRM'(gi) - head_idx;
            assign kill_mask[gi] = kill_acc & live_reg[gi] & (slot_off > kill_off);
        end
    endgenerate

    // Commit uses the registered resolved bit, so a resolve of the head
    // retires one cycle later. The head is never in kill_mask (offset 0).
    assign commit_ok = ~empty & live_reg[head_idx] & resolved_reg[head_idx];

    always_comb begin
        live_next     = live_reg;
        resolved_next = resolved_reg;
        head_next     = head_reg;
        tail_next     = tail_reg;
        if (gnt) begin
            live_next[tail_idx]     = 1'b1;
            resolved_next[tail_idx] = 1'b0;
            tail_next               = tail_reg + PW'(1);
        end
        if (res_acc) begin
            resolved_next[bus.i_res_tag] = 1'b1;
        end
        if (kill_acc) begin
            resolved_next[bus.i_res_tag] = 1'b1;
            live_next                    = live_next & ~kill_mask;
            // Rebuild tail from head so the wrap bit stays consistent.
            tail_next = head_reg + {1'b0, kill_off} + PW'(1);
        end
        if (commit_ok) begin
            live_next[head_idx] = 1'b0;
            head_next           = head_reg + PW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_reg         <= '0;
            tail_reg         <= '0;
            live_reg         <= '0;
            resolved_reg     <= '0;
            flush_reg        <= 1'b0;
            flush_mask_reg   <= '0;
            commit_valid_reg <= 1'b0;
            commit_tag_reg   <= '0;
        end else begin
            head_reg         <= head_next;
            tail_reg         <= tail_next;
            live_reg         <= live_next;
            resolved_reg     <= resolved_next;
            flush_reg        <= kill_acc;
            flush_mask_reg   <= kill_mask;
            commit_valid_reg <= commit_ok;
            if (commit_ok) begin
                commit_tag_reg <= head_idx;
            end
        end
    end

    assign bus.o_alloc_gnt    = gnt;
    assign bus.o_alloc_tag    = tail_idx;
    assign bus.o_live_mask    = live_reg;
    assign bus.o_flush        = flush_reg;
    assign bus.o_flush_mask   = flush_mask_reg;
    assign bus.o_commit_valid = commit_valid_reg;
    assign bus.o_commit_tag   = commit_tag_reg;
    assign bus.o_full         = full;
    assign bus.o_empty        = empty;
    assign bus.o_count        = count;

`ifdef BR_TAG_ALLOC_PERF_EN
    logic [31:0] kill_cnt_reg, stall_cnt_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            kill_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (kill_acc && kill_cnt_reg != 32'hFFFF_FFFF) begin
                kill_cnt_reg <= kill_cnt_reg + 32'd1;
            end
            if (bus.i_alloc_req && !gnt && stall_cnt_reg != 32'hFFFF_FFFF) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

    assign o_kill_cnt  = kill_cnt_reg;
    assign o_stall_cnt = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_br_tag_alloc.sv
// Testbench for br_tag_alloc: table of directed vectors plus hand-written
// sequences for fill-to-full, wrap-around kill and mid-flight reset.
module tb_br_tag_alloc;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    br_tag_alloc_if #(.WIDTH_BRM(4)) bus ();

`ifdef BR_TAG_ALLOC_PERF_EN
    logic [31:0] kill_cnt, stall_cnt;
    br_tag_alloc #(.WIDTH_BRM(4)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus),
        .o_kill_cnt(kill_cnt), .o_stall_cnt(stall_cnt)
    );
`else
    br_tag_alloc #(.WIDTH_BRM(4)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        req;
        logic        rv;
        logic        kill;
        logic [3:0]  tag;
        logic        egnt;
        logic [3:0]  eatag;
        logic [15:0] elive;
        logic [4:0]  ecount;
        logic        eflush;
        logic [15:0] emask;
        logic        ecv;
        logic [3:0]  ectag;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(
        input logic r, input logic q, input logic v, input logic k, input logic [3:0] t,
        input logic g, input logic [3:0] at, input logic [15:0] lv, input logic [4:0] c,
        input logic f, input logic [15:0] m, input logic cv, input logic [3:0] ct);
        vec_t x;
        x.rst = r; x.req = q; x.rv = v; x.kill = k; x.tag = t;
        x.egnt = g; x.eatag = at; x.elive = lv; x.ecount = c;
        x.eflush = f; x.emask = m; x.ecv = cv; x.ectag = ct;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs after the falling edge and let combinational outputs settle.
    task automatic cyc(input logic r, input logic q, input logic v, input logic k,
                       input logic [3:0] t);
        @(negedge clk);
        rst             = r;
        bus.i_alloc_req = q;
        bus.i_res_valid = v;
        bus.i_res_kill  = k;
        bus.i_res_tag   = t;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string pfx, input logic [15:0] lv, input logic [4:0] c,
                            input logic f, input logic [15:0] m, input logic cv,
                            input logic [3:0] ct);
        chk({pfx, " live"},   32'(bus.o_live_mask),    32'(lv));
        chk({pfx, " count"},  32'(bus.o_count),        32'(c));
        chk({pfx, " full"},   32'(bus.o_full),         32'(c == 5'd16));
        chk({pfx, " empty"},  32'(bus.o_empty),        32'(c == 5'd0));
        chk({pfx, " flush"},  32'(bus.o_flush),        32'(f));
        chk({pfx, " fmask"},  32'(bus.o_flush_mask),   32'(m));
        chk({pfx, " cvalid"}, 32'(bus.o_commit_valid), 32'(cv));
        chk({pfx, " ctag"},   32'(bus.o_commit_tag),   32'(ct));
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.i_alloc_req = 1'b0;
        bus.i_res_valid = 1'b0;
        bus.i_res_kill  = 1'b0;
        bus.i_res_tag   = 4'd0;

        //                 rst  req  rv   kill tag    gnt  atag  live      cnt   fl   mask      cv   ctag
        vecs[0]  = mk(1'b0,1'b1,1'b0,1'b0,4'd0, 1'b1,4'd0, 16'h0001,5'd1, 1'b0,16'h0000,1'b0,4'd0);
        vecs[1]  = mk(1'b0,1'b1,1'b0,1'b0,4'd0, 1'b1,4'd1, 16'h0003,5'd2, 1'b0,16'h0000,1'b0,4'd0);
        vecs[2]  = mk(1'b0,1'b1,1'b0,1'b0,4'd0, 1'b1,4'd2, 16'h0007,5'd3, 1'b0,16'h0000,1'b0,4'd0);
        vecs[3]  = mk(1'b0,1'b0,1'b1,1'b0,4'd1, 1'b0,4'd3, 16'h0007,5'd3, 1'b0,16'h0000,1'b0,4'd0);
        vecs[4]  = mk(1'b0,1'b0,1'b1,1'b0,4'd0, 1'b0,4'd3, 16'h0007,5'd3, 1'b0,16'h0000,1'b0,4'd0);
        vecs[5]  = mk(1'b0,1'b0,1'b0,1'b0,4'd0, 1'b0,4'd3, 16'h0006,5'd2, 1'b0,16'h0000,1'b1,4'd0);
        vecs[6]  = mk(1'b0,1'b0,1'b0,1'b0,4'd0, 1'b0,4'd3, 16'h0004,5'd1, 1'b0,16'h0000,1'b1,4'd1);
        vecs[7]  = mk(1'b0,1'b0,1'b0,1'b0,4'd0, 1'b0,4'd3, 16'h0004,5'd1, 1'b0,16'h0000,1'b0,4'd1);
        vecs[8]  = mk(1'b1,1'b0,1'b0,1'b0,4'd0, 1'b0,4'd3, 16'h0000,5'd0, 1'b0,16'h0000,1'b0,4'd0);
        vecs[9]  = mk(1'b0,1'b1,1'b0,1'b0,4'd0, 1'b1,4'd0, 16'h0001,5'd1, 1'b0,16'h0000,1'b0,4'd0);
        vecs[10] = mk(1'b0,1'b1,1'b0,1'b0,4'd0, 1'b1,4'd1, 16'h0003,5'd2, 1'b0,16'h0000,1'b0,4'd0);
        vecs[11] = mk(1'b0,1'b1,1'b0,1'b0,4'd0, 1'b1,4'd2, 16'h0007,5'd3, 1'b0,16'h0000,1'b0,4'd0);
        vecs[12] = mk(1'b0,1'b1,1'b0,1'b0,4'd0, 1'b1,4'd3, 16'h000F,5'd4, 1'b0,16'h0000,1'b0,4'd0);
        vecs[13] = mk(1'b0,1'b1,1'b0,1'b0,4'd0, 1'b1,4'd4, 16'h001F,5'd5, 1'b0,16'h0000,1'b0,4'd0);
        vecs[14] = mk(1'b0,1'b1,1'b1,1'b1,4'd1, 1'b0,4'd5, 16'h0003,5'd2, 1'b1,16'h001C,1'b0,4'd0);
        vecs[15] = mk(1'b0,1'b1,1'b0,1'b0,4'd0, 1'b1,4'd2, 16'h0007,5'd3, 1'b0,16'h0000,1'b0,4'd0);
        vecs[16] = mk(1'b0,1'b0,1'b0,1'b1,4'd0, 1'b0,4'd3, 16'h0007,5'd3, 1'b0,16'h0000,1'b0,4'd0);
        vecs[17] = mk(1'b0,1'b1,1'b1,1'b1,4'd9, 1'b1,4'd3, 16'h000F,5'd4, 1'b0,16'h0000,1'b0,4'd0);
        vecs[18] = mk(1'b0,1'b1,1'b1,1'b1,4'd3, 1'b0,4'd4, 16'h000F,5'd4, 1'b1,16'h0000,1'b0,4'd0);
        vecs[19] = mk(1'b0,1'b0,1'b1,1'b0,4'd0, 1'b0,4'd4, 16'h000F,5'd4, 1'b0,16'h0000,1'b0,4'd0);
        vecs[20] = mk(1'b0,1'b0,1'b0,1'b0,4'd0, 1'b0,4'd4, 16'h000E,5'd3, 1'b0,16'h0000,1'b1,4'd0);
        vecs[21] = mk(1'b0,1'b0,1'b0,1'b0,4'd0, 1'b0,4'd4, 16'h000C,5'd2, 1'b0,16'h0000,1'b1,4'd1);
        vecs[22] = mk(1'b0,1'b0,1'b1,1'b1,4'd2, 1'b0,4'd4, 16'h0004,5'd1, 1'b1,16'h0008,1'b0,4'd1);
        vecs[23] = mk(1'b0,1'b0,1'b0,1'b0,4'd0, 1'b0,4'd3, 16'h0000,5'd0, 1'b0,16'h0000,1'b1,4'd2);

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        tick();
        chk_regs("reset", 16'h0000, 5'd0, 1'b0, 16'h0000, 1'b0, 4'd0);
        $display("reset: live=%h count=%0d empty=%0b", bus.o_live_mask, bus.o_count, bus.o_empty);

        // Table-driven vectors
        for (int i = 0; i < 24; i++) begin
            cyc(vecs[i].rst, vecs[i].req, vecs[i].rv, vecs[i].kill, vecs[i].tag);
            chk($sformatf("v%0d gnt", i), 32'(bus.o_alloc_gnt), 32'(vecs[i].egnt));
            chk($sformatf("v%0d atag", i), 32'(bus.o_alloc_tag), 32'(vecs[i].eatag));
            tick();
            chk_regs($sformatf("v%0d", i), vecs[i].elive, vecs[i].ecount, vecs[i].eflush,
                     vecs[i].emask, vecs[i].ecv, vecs[i].ectag);
            $display("vec %0d: rst=%0b req=%0b rv=%0b kill=%0b tag=%0d -> live=%h cnt=%0d flush=%0b mask=%h cv=%0b ctag=%0d",
                     i, vecs[i].rst, vecs[i].req, vecs[i].rv, vecs[i].kill, vecs[i].tag,
                     bus.o_live_mask, bus.o_count, bus.o_flush, bus.o_flush_mask,
                     bus.o_commit_valid, bus.o_commit_tag);
        end

        // Fill to full, then a 17th request is refused
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
            chk($sformatf("fill%0d gnt", i), 32'(bus.o_alloc_gnt), 32'd1);
            chk($sformatf("fill%0d tag", i), 32'(bus.o_alloc_tag), 32'(i));
            $display("fill %0d: gnt=%0b tag=%0d", i, bus.o_alloc_gnt, bus.o_alloc_tag);
            tick();
        end
        chk("fill full", 32'(bus.o_full), 32'd1);
        chk("fill count", 32'(bus.o_count), 32'd16);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("fill17 gnt", 32'(bus.o_alloc_gnt), 32'd0);
        tick();
        chk("fill17 count", 32'(bus.o_count), 32'd16);
        chk("fill17 live", 32'(bus.o_live_mask), 32'h0000FFFF);
        $display("fill 16: gnt=0 count=%0d", bus.o_count);

        // Wrap: advance head to 14, allocate 14,15,0,1, kill 15
        do_reset();
        for (int i = 0; i < 14; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
            chk($sformatf("adv%0d tag", i), 32'(bus.o_alloc_tag), 32'(i));
            tick();
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'(i));
            tick();
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
            tick();
            chk($sformatf("adv%0d cvalid", i), 32'(bus.o_commit_valid), 32'd1);
            chk($sformatf("adv%0d ctag", i), 32'(bus.o_commit_tag), 32'(i));
            $display("adv %0d: commit tag=%0d count=%0d", i, bus.o_commit_tag, bus.o_count);
        end
        chk("adv count", 32'(bus.o_count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
            chk($sformatf("wrap%0d gnt", i), 32'(bus.o_alloc_gnt), 32'd1);
            chk($sformatf("wrap%0d tag", i), 32'(bus.o_alloc_tag), 32'((14 + i) % 16));
            $display("wrap alloc %0d: tag=%0d", i, bus.o_alloc_tag);
            tick();
        end
        chk_regs("wrap pre", 16'hC003, 5'd4, 1'b0, 16'h0000, 1'b0, 4'd13);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd15);
        tick();
        chk_regs("wrap kill", 16'hC000, 5'd2, 1'b1, 16'h0003, 1'b0, 4'd13);
        $display("wrap kill 15: flush=%0b mask=%h", bus.o_flush, bus.o_flush_mask);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("wrap post gnt", 32'(bus.o_alloc_gnt), 32'd1);
        chk("wrap post tag", 32'(bus.o_alloc_tag), 32'd0);
        tick();
        chk("wrap post count", 32'(bus.o_count), 32'd3);

        // Mid-flight reset with count=7 and a flush pending
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
            tick();
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd6);
        tick();
        chk("midrst pre count", 32'(bus.o_count), 32'd7);
        chk("midrst pre flush", 32'(bus.o_flush), 32'd1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
        tick();
        chk_regs("midrst", 16'h0000, 5'd0, 1'b0, 16'h0000, 1'b0, 4'd0);
        $display("midrst: live=%h count=%0d flush=%0b", bus.o_live_mask, bus.o_count, bus.o_flush);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
